// File: rtl/axi_lite_mem_arbiter_pkg.sv
// Shared types and constants for the two-requester AXI-lite memory arbiter.
// Latency: none (package only).
// Backpressure: none (package only).
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WADDR = 3'd3,
    WRESP = 3'd4
  } arb_state_t;

  localparam int         NUM_REQ   = 2;
  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/axi_lite_mem_arbiter_if.sv
// AXI-lite bus bundle (AR/R/AW/W/B, no prot) with master and slave views.
// Latency: none (wiring only).
// Backpressure: plain AXI valid/ready on every channel.
interface axi_lite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_lite_mem_arbiter_pick2.sv
// Two-requester picker: on contention the port that is not `last` wins.
// Latency: combinational.
// Backpressure: none; a lone requester always wins, no request gives 2'b00.
module arb_pick2
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_last,
  output logic [NUM_REQ-1:0] o_gnt
);

  // Tying i_last low makes this fixed priority with port 1 first.
  always_comb begin
    o_gnt = i_req;
    if (&i_req) begin
      o_gnt = i_last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/axi_lite_mem_arbiter.sv
// Shares one AXI-lite memory port between icache (s0) and dcache (s1), one transaction at a time.
// Latency: 1-cycle arbitration bubble, then AR/R or AW+W/B forwarded; one IDLE cycle after each.
// Backpressure: owner locked until R/B handshake; loser sees ready/valid 0. AXI_ARB_ROUND_ROBIN_EN selects round-robin.
module axi_lite_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  axi_lite_if.slave        s0_axi,
  axi_lite_if.slave        s1_axi,
  axi_lite_if.master       m_axi,
  output logic [1:0]       grant,
  output logic             busy
);

  arb_state_t           r_state;
  logic                 r_sel;
  logic                 r_aw_done;
  logic                 r_w_done;
  logic [NUM_REQ-1:0]   r_grant;

  logic [NUM_REQ-1:0]   w_req;
  logic [NUM_REQ-1:0]   w_gnt;
  logic                 w_last;
  logic                 w_win_ar;

  logic [ADDR_W-1:0]    w_s_araddr;
  logic                 w_s_arvalid;
  logic                 w_s_rready;
  logic [ADDR_W-1:0]    w_s_awaddr;
  logic                 w_s_awvalid;
  logic [DATA_W-1:0]    w_s_wdata;
  logic [DATA_W/8-1:0]  w_s_wstrb;
  logic                 w_s_wvalid;
  logic                 w_s_bready;

  logic w_in_raddr, w_in_rdata, w_in_waddr, w_in_wresp;
  logic w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs, w_aw_fin, w_w_fin;
  logic w_ar_rdy, w_r_vld, w_aw_rdy, w_w_rdy, w_b_vld;

  assign w_req    = {s1_axi.arvalid | s1_axi.awvalid, s0_axi.arvalid | s0_axi.awvalid};
  assign w_win_ar = w_gnt[1] ? s1_axi.arvalid : s0_axi.arvalid;

  arb_pick2 u_pick (
    .i_req  (w_req),
    .i_last (w_last),
    .o_gnt  (w_gnt)
  );

`ifdef AXI_ARB_ROUND_ROBIN_EN
  logic r_last;
  // Remember the latest owner; starts at 1 so port 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (!rst_n)                           r_last <= 1'b1;
    else if (r_state == IDLE && |w_gnt)   r_last <= w_gnt[1];
  end
  assign w_last = r_last;
`else
  assign w_last = 1'b0;
`endif

  // Owner-side request signals, selected only by the registered owner index.
  assign w_s_araddr  = r_sel ? s1_axi.araddr  : s0_axi.araddr;
  assign w_s_arvalid = r_sel ? s1_axi.arvalid : s0_axi.arvalid;
  assign w_s_rready  = r_sel ? s1_axi.rready  : s0_axi.rready;
  assign w_s_awaddr  = r_sel ? s1_axi.awaddr  : s0_axi.awaddr;
  assign w_s_awvalid = r_sel ? s1_axi.awvalid : s0_axi.awvalid;
  assign w_s_wdata   = r_sel ? s1_axi.wdata   : s0_axi.wdata;
  assign w_s_wstrb   = r_sel ? s1_axi.wstrb   : s0_axi.wstrb;
  assign w_s_wvalid  = r_sel ? s1_axi.wvalid  : s0_axi.wvalid;
  assign w_s_bready  = r_sel ? s1_axi.bready  : s0_axi.bready;

  assign w_in_raddr = (r_state == RADDR);
  assign w_in_rdata = (r_state == RDATA);
  assign w_in_waddr = (r_state == WADDR);
  assign w_in_wresp = (r_state == WRESP);

  // Memory side: each channel is open only in its own state; AW/W close once done.
  assign m_axi.arvalid = w_in_raddr & w_s_arvalid;
  assign m_axi.araddr  = w_in_raddr ? w_s_araddr : '0;
  assign m_axi.rready  = w_in_rdata & w_s_rready;
  assign m_axi.awvalid = w_in_waddr & ~r_aw_done & w_s_awvalid;
  assign m_axi.awaddr  = w_in_waddr ? w_s_awaddr : '0;
  assign m_axi.wvalid  = w_in_waddr & ~r_w_done & w_s_wvalid;
  assign m_axi.wdata   = w_in_waddr ? w_s_wdata : '0;
  assign m_axi.wstrb   = w_in_waddr ? w_s_wstrb : '0;
  assign m_axi.bready  = w_in_wresp & w_s_bready;

  assign w_ar_rdy = w_in_raddr & m_axi.arready;
  assign w_r_vld  = w_in_rdata & m_axi.rvalid;
  assign w_aw_rdy = w_in_waddr & ~r_aw_done & m_axi.awready;
  assign w_w_rdy  = w_in_waddr & ~r_w_done & m_axi.wready;
  assign w_b_vld  = w_in_wresp & m_axi.bvalid;

  assign w_ar_hs  = m_axi.arvalid & m_axi.arready;
  assign w_r_hs   = w_r_vld & m_axi.rready;
  assign w_aw_hs  = m_axi.awvalid & m_axi.awready;
  assign w_w_hs   = m_axi.wvalid & m_axi.wready;
  assign w_b_hs   = w_b_vld & m_axi.bready;
  assign w_aw_fin = r_aw_done | w_aw_hs;
  assign w_w_fin  = r_w_done | w_w_hs;

  // Requester side: only the owner ever sees ready/valid or response data.
  assign s0_axi.arready = ~r_sel & w_ar_rdy;
  assign s0_axi.rvalid  = ~r_sel & w_r_vld;
  assign s0_axi.rdata   = (~r_sel & w_in_rdata) ? m_axi.rdata : '0;
  assign s0_axi.rresp   = (~r_sel & w_in_rdata) ? m_axi.rresp : RESP_OKAY;
  assign s0_axi.awready = ~r_sel & w_aw_rdy;
  assign s0_axi.wready  = ~r_sel & w_w_rdy;
  assign s0_axi.bvalid  = ~r_sel & w_b_vld;
  assign s0_axi.bresp   = (~r_sel & w_in_wresp) ? m_axi.bresp : RESP_OKAY;

  assign s1_axi.arready = r_sel & w_ar_rdy;
  assign s1_axi.rvalid  = r_sel & w_r_vld;
  assign s1_axi.rdata   = (r_sel & w_in_rdata) ? m_axi.rdata : '0;
  assign s1_axi.rresp   = (r_sel & w_in_rdata) ? m_axi.rresp : RESP_OKAY;
  assign s1_axi.awready = r_sel & w_aw_rdy;
  assign s1_axi.wready  = r_sel & w_w_rdy;
  assign s1_axi.bvalid  = r_sel & w_b_vld;
  assign s1_axi.bresp   = (r_sel & w_in_wresp) ? m_axi.bresp : RESP_OKAY;

  assign grant = r_grant;
  assign busy  = (r_state != IDLE);

  // Transaction FSM: arbitrate in IDLE, lock the owner until its R or B handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_sel     <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_grant   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_gnt) begin
            r_sel   <= w_gnt[1];
            r_grant <= w_gnt;
            r_state <= w_win_ar ? RADDR : WADDR;
          end
        end
        RADDR: if (w_ar_hs) r_state <= RDATA;
        RDATA: begin
          if (w_r_hs) begin
            r_state <= IDLE;
            r_grant <= '0;
          end
        end
        WADDR: begin
          if (w_aw_fin && w_w_fin) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_state   <= WRESP;
          end else begin
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
          end
        end
        WRESP: begin
          if (w_b_hs) begin
            r_state <= IDLE;
            r_grant <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
// Directed bench for axi_lite_mem_arbiter: reads, contention, skewed write, same-port mix, policy order, reset.
// Latency: checks arbitration bubble and per-state forwarding at each negedge.
// Backpressure: memory readies/valids driven by hand to create skew and stalls.
module tb_axi_lite_mem_arbiter;
  import mem_arb_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [1:0] grant;
  logic       busy;
  int         checks;
  int         failures;
  int         aw_cnt;
  int         w_cnt;
  int         aw_base;
  int         w_base;
  logic [1:0] rr_exp [4];

  axi_lite_if #(.ADDR_W(32), .DATA_W(32)) s0_if ();
  axi_lite_if #(.ADDR_W(32), .DATA_W(32)) s1_if ();
  axi_lite_if #(.ADDR_W(32), .DATA_W(32)) m_if ();

  axi_lite_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s0_axi (s0_if),
    .s1_axi (s1_if),
    .m_axi  (m_if),
    .grant  (grant),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count memory-side AW and W handshakes.
  always @(posedge clk) begin
    if (m_if.awvalid && m_if.awready) aw_cnt <= aw_cnt + 1;
    if (m_if.wvalid && m_if.wready)   w_cnt  <= w_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    checks = 0; failures = 0; aw_cnt = 0; w_cnt = 0;
`ifdef AXI_ARB_ROUND_ROBIN_EN
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
`else
    rr_exp[0] = 2'b10; rr_exp[1] = 2'b10; rr_exp[2] = 2'b10; rr_exp[3] = 2'b10;
`endif
    rst_n = 1'b0;
    s0_if.araddr = '0; s0_if.arvalid = 0; s0_if.rready = 0; s0_if.awaddr = '0; s0_if.awvalid = 0;
    s0_if.wdata = '0; s0_if.wstrb = '0; s0_if.wvalid = 0; s0_if.bready = 0;
    s1_if.araddr = '0; s1_if.arvalid = 0; s1_if.rready = 0; s1_if.awaddr = '0; s1_if.awvalid = 0;
    s1_if.wdata = '0; s1_if.wstrb = '0; s1_if.wvalid = 0; s1_if.bready = 0;
    m_if.arready = 0; m_if.rdata = '0; m_if.rresp = '0; m_if.rvalid = 0;
    m_if.awready = 0; m_if.wready = 0; m_if.bresp = '0; m_if.bvalid = 0;

    // Reset state
    nxt(); nxt();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_m_valids", 32'({m_if.arvalid, m_if.awvalid, m_if.wvalid, m_if.rready, m_if.bready}), 32'h0);
    chk("rst_m_araddr", m_if.araddr, 32'h0);
    chk("rst_s_readies", 32'({s0_if.arready, s0_if.awready, s0_if.wready, s1_if.arready, s1_if.awready, s1_if.wready}), 32'h0);
    chk("rst_s_rsp", 32'({s0_if.rvalid, s0_if.bvalid, s1_if.rvalid, s1_if.bvalid}), 32'h0);
    rst_n = 1'b1;

    // Solo read from s0
    nxt();
    s0_if.araddr = 32'h100; s0_if.arvalid = 1; s0_if.rready = 1;
    #1 chk("solo_no_comb_arvalid", 32'(m_if.arvalid), 32'h0);
    nxt();
    chk("solo_grant", 32'(grant), 32'h1);
    chk("solo_busy", 32'(busy), 32'h1);
    chk("solo_araddr", m_if.araddr, 32'h100);
    chk("solo_arvalid", 32'(m_if.arvalid), 32'h1);
    m_if.arready = 1;
    #1 chk("solo_arready_fwd", 32'(s0_if.arready), 32'h1);
    nxt();
    s0_if.arvalid = 0; m_if.arready = 0;
    chk("solo_rready_fwd", 32'(m_if.rready), 32'h1);
    m_if.rvalid = 1; m_if.rdata = 32'hDEADBEEF;
    #1 chk("solo_rvalid", 32'(s0_if.rvalid), 32'h1);
    chk("solo_rdata", s0_if.rdata, 32'hDEADBEEF);
    chk("solo_s1_rvalid", 32'(s1_if.rvalid), 32'h0);
    nxt();
    m_if.rvalid = 0; m_if.rdata = '0;
    chk("solo_idle_grant", 32'(grant), 32'h0);
    chk("solo_idle_busy", 32'(busy), 32'h0);

    // Contention on AR: s1 first, then s0
    s0_if.araddr = 32'h100; s0_if.arvalid = 1;
    s1_if.araddr = 32'h200; s1_if.arvalid = 1; s1_if.rready = 1;
    nxt();
    chk("cont_grant_s1", 32'(grant), 32'h2);
    chk("cont_araddr_s1", m_if.araddr, 32'h200);
    m_if.arready = 1;
    #1 chk("cont_s1_arready", 32'(s1_if.arready), 32'h1);
    chk("cont_s0_arready_held", 32'(s0_if.arready), 32'h0);
    nxt();
    s1_if.arvalid = 0; m_if.arready = 0; m_if.rvalid = 1; m_if.rdata = 32'h2222;
    #1 chk("cont_s1_rdata", s1_if.rdata, 32'h2222);
    chk("cont_s0_rvalid", 32'(s0_if.rvalid), 32'h0);
    nxt();
    m_if.rvalid = 0;
    chk("cont_bubble_grant", 32'(grant), 32'h0);
    nxt();
    chk("cont_grant_s0", 32'(grant), 32'h1);
    chk("cont_araddr_s0", m_if.araddr, 32'h100);
    m_if.arready = 1;
    nxt();
    s0_if.arvalid = 0; m_if.arready = 0; m_if.rvalid = 1; m_if.rdata = 32'h1111;
    #1 chk("cont_s0_rdata", s0_if.rdata, 32'h1111);
    nxt();
    m_if.rvalid = 0;
    chk("cont_end_busy", 32'(busy), 32'h0);

    // Write from s1 with W accepted 3 cycles before AW
    aw_base = aw_cnt; w_base = w_cnt;
    s1_if.awaddr = 32'h40; s1_if.awvalid = 1; s1_if.wdata = 32'h12345678;
    s1_if.wstrb = 4'hF; s1_if.wvalid = 1; s1_if.bready = 1;
    nxt();
    chk("wr_grant", 32'(grant), 32'h2);
    chk("wr_awaddr", m_if.awaddr, 32'h40);
    chk("wr_wdata", m_if.wdata, 32'h12345678);
    chk("wr_wstrb", 32'(m_if.wstrb), 32'hF);
    m_if.wready = 1;
    #1 chk("wr_s1_wready", 32'(s1_if.wready), 32'h1);
    nxt();
    s1_if.wvalid = 0;
    #1 chk("wr_wready_masked", 32'(s1_if.wready), 32'h0);
    chk("wr_wvalid_masked", 32'(m_if.wvalid), 32'h0);
    nxt();
    chk("wr_still_waddr_busy", 32'(busy), 32'h1);
    nxt();
    m_if.awready = 1;
    #1 chk("wr_s1_awready", 32'(s1_if.awready), 32'h1);
    nxt();
    s1_if.awvalid = 0; m_if.awready = 0; m_if.wready = 0;
    chk("wr_aw_count", aw_cnt - aw_base, 32'd1);
    chk("wr_w_count", w_cnt - w_base, 32'd1);
    chk("wr_bready", 32'(m_if.bready), 32'h1);
    m_if.bvalid = 1; m_if.bresp = RESP_OKAY;
    #1 chk("wr_s1_bvalid", 32'(s1_if.bvalid), 32'h1);
    chk("wr_s1_bresp", 32'(s1_if.bresp), 32'(RESP_OKAY));
    chk("wr_s0_bvalid", 32'(s0_if.bvalid), 32'h0);
    nxt();
    m_if.bvalid = 0;
    chk("wr_end_busy", 32'(busy), 32'h0);

    // Same-port read and write on s1: read first
    s1_if.araddr = 32'h80; s1_if.arvalid = 1;
    s1_if.awaddr = 32'h84; s1_if.awvalid = 1; s1_if.wdata = 32'hA5A5A5A5; s1_if.wstrb = 4'h3; s1_if.wvalid = 1;
    nxt();
    chk("mix_rd_grant", 32'(grant), 32'h2);
    chk("mix_rd_arvalid", 32'(m_if.arvalid), 32'h1);
    chk("mix_rd_no_awvalid", 32'(m_if.awvalid), 32'h0);
    m_if.arready = 1;
    nxt();
    s1_if.arvalid = 0; m_if.arready = 0; m_if.rvalid = 1; m_if.rdata = 32'hCAFE;
    #1 chk("mix_rd_rdata", s1_if.rdata, 32'hCAFE);
    nxt();
    m_if.rvalid = 0;
    chk("mix_idle_grant", 32'(grant), 32'h0);
    nxt();
    chk("mix_wr_grant", 32'(grant), 32'h2);
    chk("mix_wr_awaddr", m_if.awaddr, 32'h84);
    chk("mix_wr_wdata", m_if.wdata, 32'hA5A5A5A5);
    m_if.awready = 1; m_if.wready = 1;
    nxt();
    s1_if.awvalid = 0; s1_if.wvalid = 0; m_if.awready = 0; m_if.wready = 0;
    chk("mix_wresp_bready", 32'(m_if.bready), 32'h1);
    m_if.bvalid = 1;
    #1 chk("mix_bvalid", 32'(s1_if.bvalid), 32'h1);
    nxt();
    m_if.bvalid = 0;
    chk("mix_end_busy", 32'(busy), 32'h0);

    // Continuous contention: grant order follows the configured policy
    s0_if.araddr = 32'h10; s0_if.arvalid = 1;
    s1_if.araddr = 32'h20; s1_if.arvalid = 1;
    for (int k = 0; k < 4; k++) begin
      nxt();
      chk($sformatf("order_grant_%0d", k), 32'(grant), 32'(rr_exp[k]));
      m_if.arready = 1;
      nxt();
      m_if.arready = 0; m_if.rvalid = 1;
      nxt();
      m_if.rvalid = 0;
    end
    s0_if.arvalid = 0; s1_if.arvalid = 0;

    // Reset while waiting for read data
    nxt();
    s0_if.araddr = 32'h300; s0_if.arvalid = 1;
    nxt();
    chk("rstmid_grant", 32'(grant), 32'h1);
    m_if.arready = 1;
    nxt();
    m_if.arready = 0; s0_if.arvalid = 0;
    chk("rstmid_in_rdata", 32'(m_if.rready), 32'h1);
    rst_n = 0;
    nxt();
    rst_n = 1; m_if.rvalid = 1; m_if.rdata = 32'h5555;
    #1 chk("rstmid_busy", 32'(busy), 32'h0);
    chk("rstmid_grant0", 32'(grant), 32'h0);
    chk("rstmid_s0_rvalid", 32'(s0_if.rvalid), 32'h0);
    chk("rstmid_m_valids", 32'({m_if.arvalid, m_if.awvalid, m_if.wvalid, m_if.rready, m_if.bready}), 32'h0);
    nxt();
    m_if.rvalid = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_lite_mem_arbiter.md
Name: axi_lite_mem_arbiter

Overview:
- Shares one AXI-lite master port (to main memory) between two AXI-lite requesters: port 0 is the icache refill path, port 1 is the dcache/LSU path.
- Only one transaction (one read or one write) is outstanding at a time. The owner is locked until its final handshake (R or B).
- Sits between the cache masters and the memory/interconnect slave.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; the strobe width is DATA_W/8.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- s0_axi  axi_lite_if.slave  interface  requester 0 (icache).
- s1_axi  axi_lite_if.slave  interface  requester 1 (dcache).
- m_axi  axi_lite_if.master  interface  shared memory port.
- grant  output  2  one-hot current owner; 2'b00 when idle.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, RADDR, RDATA, WADDR, WRESP.
- Registered owner index `sel` and registered flags `aw_done`, `w_done`.
- Reset outputs:
  - m_axi arvalid/awvalid/wvalid/rready/bready = 0; araddr/awaddr/wdata/wstrb = 0.
  - All s*_axi arready/awready/wready/rvalid/bvalid = 0; rdata = 0; rresp/bresp = 0.
  - grant = 0, busy = 0, state = IDLE.
- Request detection: requester i requests when arvalid_i or awvalid_i is high.
- Arbitration (IDLE only):
  - Default policy: fixed priority, port 1 wins over port 0.
  - If the winner has arvalid, go to RADDR. Otherwise go to WADDR. Read beats write when both valids are set on the same port.
  - Decision is registered, so there is a 1-cycle arbitration bubble. Minimum read latency is IDLE→RADDR→RDATA→IDLE.
- RADDR:
  - m_axi.araddr/arvalid are driven from s[sel]. s[sel].arready = m_axi.arready.
  - On the m_axi AR handshake, go to RDATA.
- RDATA:
  - m_axi.rready = s[sel].rready. s[sel].rvalid/rdata/rresp are driven from m_axi.
  - On the R handshake, go to IDLE.
- WADDR:
  - AW and W are forwarded independently from s[sel]. Each is masked once its done-flag is set.
  - When both are done (handshake this cycle or flag already set), clear the flags and go to WRESP.
  - AW and W may complete in the same cycle or in any order.
- WRESP:
  - B is forwarded: m_axi.bready = s[sel].bready; s[sel].bvalid/bresp are driven from m_axi.
  - On the B handshake, go to IDLE.
- Non-granted port: all its ready/valid outputs are held 0. Its pending valids stay pending, because AXI requires a master to hold valid until handshake.
- No back-to-back grant without passing through IDLE. Every transaction ends with one IDLE cycle.
- Mux selection comes only from registered `sel`, never from the current request inputs. There is no combinational path from s*_valid to m_axi valid in the same cycle as arbitration.
- Reset mid-transaction: return to IDLE immediately and clear the flags. Any in-flight memory response is discarded; the system resets all masters together.

Optional Feature:
- Macro: AXI_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. A registered `last` bit records the most recent owner. On contention, the other port wins. `last` resets to 1, so port 0 wins the first contention.
- Undefined: fixed priority, port 1 first. `last` register is not instantiated.

Decomposition:
- Shared package `mem_arb_pkg`:
  - state enum `arb_state_t` {IDLE, RADDR, RDATA, WADDR, WRESP}.
  - localparams NUM_REQ = 2 and RESP_OKAY = 2'b00.
- Sub-module `arb_pick2`: combinational two-requester picker.
  - Inputs: req[1:0], last.
  - Output: one-hot gnt.
  - Holds the priority/round-robin logic so the policy is swappable.

Test Plan:
- Solo read: s0 araddr=0x100, memory returns 0xDEADBEEF → m_axi.araddr=0x100 one cycle after request; s0 gets rdata=0xDEADBEEF; grant=01 during the transaction; then IDLE.
- Contention, fixed priority: s0 and s1 raise arvalid in the same cycle (0x100, 0x200) → s1 served first (araddr 0x200), then s0 (0x100). s0 arready stays 0 during s1's transaction.
- Write with skew: s1 awaddr=0x40, wdata=0x12345678, wstrb=0xF; memory asserts wready 3 cycles before awready → exactly one AW and one W handshake, then B OKAY to s1. s0 bvalid stays 0.
- Same-port read+write: s1 raises arvalid and awvalid together → read completes first, then write via a separate grant.
- Round-robin (macro defined): continuous requests on both ports for 4 transactions → grant order 01, 10, 01, 10.
- Reset in RDATA: rst_n low for 1 cycle while waiting for rvalid → next cycle state=IDLE, grant=0, all valid/ready outputs 0.
